// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised, glitch-filtered frame capture, E0/F0 prefix
// folding into tagged key events, and a valid/ready event FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2Clk,
    input  logic       data,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_brk,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic [7:0] err_count
);
    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic          c1_q, c2_q, d1_q, d2_q;
    logic          fclk_q, fclk_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_d, acc_d;
    logic          ferr_q, acc_q;
    logic [7:0]    ecnt_q;

    logic          ext_q, brk_q;
    logic          is_e0, is_f0, push_req, push, pop, empty, full, ovf_q;
    logic [AW:0]   wr_q, rd_q;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [9:0]    head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c1_q   <= 1'b1;
            c2_q   <= 1'b1;
            d1_q   <= 1'b1;
            d2_q   <= 1'b1;
            fclk_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            c1_q   <= PS2Clk;
            c2_q   <= c1_q;
            d1_q   <= data;
            d2_q   <= d1_q;
            fclk_q <= fclk_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Count consecutive samples disagreeing with the filtered clock; flip on the FILTER_LEN-th.
    always_comb begin
        fclk_d = fclk_q;
        fcnt_d = '0;
        if (c2_q != fclk_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) fclk_d = c2_q;
            else                               fcnt_d = fcnt_q + FW'(1);
        end
    end

    assign fall = fclk_q & ~fclk_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && !d2_q) begin
                    state_d = SHIFT;
                    idx_d   = 4'd1;
                end
            end
            SHIFT: begin
                if (fall) begin
                    tmo_d = '0;
                    idx_d = idx_q + 4'd1;
                    if (idx_q <= 4'd8)       sh_d    = {d2_q, sh_q[7:1]};
                    else if (idx_q == 4'd9)  par_d   = d2_q;
                    else                     state_d = IDLE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d = 1'b0;
        acc_d = 1'b0;
        case (state_q)
            IDLE:  err_d = fall & d2_q;
            SHIFT: begin
                if (fall) begin
                    if (idx_q >= 4'd10) begin
                        acc_d = (^sh_q ^ par_q) & d2_q;
                        err_d = ~acc_d;
                    end
                end else begin
                    err_d = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
                end
            end
            default: ;
        endcase
    end

    // sh_q stays stable in IDLE, so the accepted byte is read directly one cycle later.
    assign is_e0    = (sh_q == 8'hE0);
    assign is_f0    = (sh_q == 8'hF0);
    assign push_req = acc_q & ~is_e0 & ~is_f0;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = ~empty & ev_ready;
    assign push  = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ferr_q <= 1'b0;
            acc_q  <= 1'b0;
            ecnt_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ferr_q <= err_d;
            acc_q  <= acc_d;
            if (err_d && ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
            if (ferr_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (acc_q) begin
                if (is_e0)      ext_q <= 1'b1;
                else if (is_f0) brk_q <= 1'b1;
                else begin
                    ext_q <= 1'b0;
                    brk_q <= 1'b0;
                end
            end
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop)  rd_q <= rd_q + (AW+1)'(1);
            ovf_q <= push_req & full & ~pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {sh_q, ext_q, brk_q};
    end

    assign head      = mem_q[rd_q[AW-1:0]];
    assign ev_valid  = ~empty;
    assign ev_code   = ev_valid ? head[9:2] : 8'h00;
    assign ev_ext    = ev_valid & head[1];
    assign ev_brk    = ev_valid & head[0];
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;
    assign err_count = ecnt_q;
endmodule
